rx_resp_collector: RTL and testbench

Parametrised response-collection stage between the switch instances and the unit-address decoder's read-back path. It tracks outstanding operations per switch in per-channel op_id FIFOs and captures each switch's read data on `ack`. It arbitrates completed responses round-robin onto a single valid/ready output carrying data, op_id and source index, and flags protocol errors (overflow, spurious ack, response loss).

---
 rtl/rx_pkg.sv | 27 ++
 rtl/rx_resp_collector_if.sv | 34 +++
 rtl/rx_id_fifo.sv | 61 ++++++
 rtl/rx_resp_collector.sv | 166 ++++++++++++++++
 tb/tb_rx_resp_collector.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared constants and elaboration-time helpers for the response collector.
package rx_pkg;

    // Bit positions inside the sticky err_flags vector.
    localparam int ERR_OVF  = 0;
    localparam int ERR_SPUR = 1;
    localparam int ERR_LOST = 2;

    // Ceiling log2, used for pointer, counter and index widths.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_resp_collector_if.sv
// Issue/completion/response bundle between the switch side and the read-back path.
interface rx_resp_collector_if
    import rx_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int ID_WIDTH    = 8
);
    localparam int IDX_W = idx_width(NUM_SW_INST);

    logic [NUM_SW_INST-1:0]         sel_en;
    logic [ID_WIDTH-1:0]            op_id;
    logic [NUM_SW_INST*W_WIDTH-1:0] rd_data;
    logic [NUM_SW_INST-1:0]         ack;
    logic                           out_ready;
    logic                           out_valid;
    logic [W_WIDTH-1:0]             rd_data_out;
    logic [ID_WIDTH-1:0]            op_id_out;
    logic [IDX_W-1:0]               sw_idx_out;
    logic [NUM_SW_INST-1:0]         sw_busy;
    logic [NUM_SW_INST-1:0]         sw_full;
    logic [2:0]                     err_flags;

    modport master (
        output sel_en, op_id, rd_data, ack, out_ready,
        input  out_valid, rd_data_out, op_id_out, sw_idx_out, sw_busy, sw_full, err_flags
    );

    modport slave (
        input  sel_en, op_id, rd_data, ack, out_ready,
        output out_valid, rd_data_out, op_id_out, sw_idx_out, sw_busy, sw_full, err_flags
    );

endinterface

// File: rtl/rx_id_fifo.sv
// Per-channel op_id FIFO with show-ahead output. The caller guarantees that
// pushes only occur when there is room (or a pop in the same cycle) and pops
// only when non-empty.
module rx_id_fifo
    import rx_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = clog2(FIFO_DEPTH),
    localparam int CW = clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [ID_WIDTH-1:0] din_i,
    output logic [ID_WIDTH-1:0] dout_o,
    output logic [CW-1:0]       count_o,
    output logic                empty_o,
    output logic                full_o
);

    logic [ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       cnt_q;

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            cnt_q    <= CW'(0);
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == CW'(0));
    assign full_o  = (cnt_q == CW'(FIFO_DEPTH));

endmodule

// File: rtl/rx_resp_collector.sv
// Collects per-switch responses: op_id FIFOs track outstanding issues, one
// pending slot per channel holds a completed response, and a round-robin
// arbiter moves slots into a single held valid/ready output register.
module rx_resp_collector
    import rx_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int ID_WIDTH    = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    rx_resp_collector_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_SW_INST);
    localparam int CW    = clog2(FIFO_DEPTH + 1);

    logic [NUM_SW_INST-1:0] fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic [NUM_SW_INST-1:0] ovf_s, spur_s, lost_s, grant_s;
    logic [ID_WIDTH-1:0]    fifo_dout_s [NUM_SW_INST];
    logic [CW-1:0]          fifo_cnt_s  [NUM_SW_INST];

    logic [NUM_SW_INST-1:0] slot_vld_q, slot_vld_d;
    logic [W_WIDTH-1:0]     slot_data_q [NUM_SW_INST];
    logic [W_WIDTH-1:0]     slot_data_d [NUM_SW_INST];
    logic [ID_WIDTH-1:0]    slot_id_q   [NUM_SW_INST];
    logic [ID_WIDTH-1:0]    slot_id_d   [NUM_SW_INST];

    logic                   out_valid_q, out_valid_d;
    logic [W_WIDTH-1:0]     rd_data_out_q, rd_data_out_d;
    logic [ID_WIDTH-1:0]    op_id_out_q, op_id_out_d;
    logic [IDX_W-1:0]       sw_idx_out_q, sw_idx_out_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]             err_q, err_d;

    logic                   load_s, gnt_any_s;
    logic [IDX_W-1:0]       gnt_idx_s, cand_s;

    // The output register may take a new response when empty or being accepted.
    assign load_s = !out_valid_q || bus.out_ready;

    for (genvar i = 0; i < NUM_SW_INST; i++) begin : g_ch
        rx_id_fifo #(
            .ID_WIDTH   (ID_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_s[i]),
            .pop_i   (pop_s[i]),
            .din_i   (bus.op_id),
            .dout_o  (fifo_dout_s[i]),
            .count_o (fifo_cnt_s[i]),
            .empty_o (fifo_empty_s[i]),
            .full_o  (fifo_full_s[i])
        );

        // An ack against an empty FIFO never pops, even if an issue lands the same cycle.
        assign pop_s[i]   = bus.ack[i] & ~fifo_empty_s[i];
        assign push_s[i]  = bus.sel_en[i] & (~fifo_full_s[i] | pop_s[i]);
        assign ovf_s[i]   = bus.sel_en[i] & fifo_full_s[i] & ~pop_s[i];
        assign spur_s[i]  = bus.ack[i] & fifo_empty_s[i];
        assign lost_s[i]  = pop_s[i] & slot_vld_q[i] & ~grant_s[i];
        assign bus.sw_busy[i] = (fifo_cnt_s[i] != CW'(0));
        assign bus.sw_full[i] = fifo_full_s[i];
    end

    // Round-robin search over valid slots starting at rr_ptr; grants only when the output can load.
    always_comb begin
        grant_s   = '0;
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int k = 0; k < NUM_SW_INST; k++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + k) % NUM_SW_INST);
            if (load_s && !gnt_any_s && slot_vld_q[cand_s]) begin
                gnt_any_s       = 1'b1;
                gnt_idx_s       = cand_s;
                grant_s[cand_s] = 1'b1;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Pending slots: load on pop if free or leaving this cycle, clear on grant, else hold.
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_data_d = slot_data_q;
        slot_id_d   = slot_id_q;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (pop_s[i] && (!slot_vld_q[i] || grant_s[i])) begin
                slot_vld_d[i]  = 1'b1;
                slot_data_d[i] = bus.rd_data[i*W_WIDTH +: W_WIDTH];
                slot_id_d[i]   = fifo_dout_s[i];
            end else if (grant_s[i]) begin
                slot_vld_d[i] = 1'b0;
            end else begin
                slot_vld_d[i] = slot_vld_q[i];
            end
        end
    end

    // Output register, round-robin pointer advance and sticky error accumulation.
    always_comb begin
        out_valid_d   = out_valid_q;
        rd_data_out_d = rd_data_out_q;
        op_id_out_d   = op_id_out_q;
        sw_idx_out_d  = sw_idx_out_q;
        rr_ptr_d      = rr_ptr_q;
        if (load_s) begin
            out_valid_d = gnt_any_s;
            if (gnt_any_s) begin
                rd_data_out_d = slot_data_q[gnt_idx_s];
                op_id_out_d   = slot_id_q[gnt_idx_s];
                sw_idx_out_d  = gnt_idx_s;
                rr_ptr_d      = (gnt_idx_s == IDX_W'(NUM_SW_INST - 1)) ? IDX_W'(0)
                                                                       : gnt_idx_s + IDX_W'(1);
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        err_d = err_q;
        err_d[ERR_OVF]  = err_q[ERR_OVF]  | (|ovf_s);
        err_d[ERR_SPUR] = err_q[ERR_SPUR] | (|spur_s);
        err_d[ERR_LOST] = err_q[ERR_LOST] | (|lost_s);
    end

    // State registers with synchronous reset that discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q    <= '0;
            out_valid_q   <= 1'b0;
            rd_data_out_q <= '0;
            op_id_out_q   <= '0;
            sw_idx_out_q  <= '0;
            rr_ptr_q      <= '0;
            err_q         <= 3'b000;
            for (int i = 0; i < NUM_SW_INST; i++) begin
                slot_data_q[i] <= '0;
                slot_id_q[i]   <= '0;
            end
        end else begin
            slot_vld_q    <= slot_vld_d;
            slot_data_q   <= slot_data_d;
            slot_id_q     <= slot_id_d;
            out_valid_q   <= out_valid_d;
            rd_data_out_q <= rd_data_out_d;
            op_id_out_q   <= op_id_out_d;
            sw_idx_out_q  <= sw_idx_out_d;
            rr_ptr_q      <= rr_ptr_d;
            err_q         <= err_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.rd_data_out = rd_data_out_q;
    assign bus.op_id_out   = op_id_out_q;
    assign bus.sw_idx_out  = sw_idx_out_q;
    assign bus.err_flags   = err_q;

endmodule

// File: tb/tb_rx_resp_collector.sv
// Directed plus randomized bench for rx_resp_collector with a queue-based reference model.
module tb_rx_resp_collector;
    import rx_pkg::*;

    localparam int N   = 5;
    localparam int W   = 8;
    localparam int IDW = 8;
    localparam int D   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rx_resp_collector_if #(.NUM_SW_INST(N), .W_WIDTH(W), .ID_WIDTH(IDW)) bus ();

    rx_resp_collector #(
        .NUM_SW_INST (N),
        .W_WIDTH     (W),
        .ID_WIDTH    (IDW),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: queues of outstanding ids, pending responses, output register.
    logic [IDW-1:0] m_q [N][$];
    logic           m_sv [N];
    logic [W-1:0]   m_sd [N];
    logic [IDW-1:0] m_si [N];
    logic           m_ov;
    logic [W-1:0]   m_od;
    logic [IDW-1:0] m_oi;
    int             m_ox;
    int             m_rr;
    logic [2:0]     m_err;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q[i].delete();
            m_sv[i] = 1'b0;
            m_sd[i] = '0;
            m_si[i] = '0;
        end
        m_ov = 1'b0; m_od = '0; m_oi = '0; m_ox = 0; m_rr = 0; m_err = 3'b000;
    endtask

    task automatic model_step(input logic [N-1:0] sel, input logic [IDW-1:0] id,
                              input logic [N-1:0] ak, input logic [N*W-1:0] dat, input logic rdy);
        int g;
        logic [IDW-1:0] popped;
        g = -1;
        if (!m_ov || rdy) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && m_sv[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) begin
                m_ov = 1'b1; m_od = m_sd[g]; m_oi = m_si[g]; m_ox = g;
                m_rr = (g + 1) % N; m_sv[g] = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ak[i]) begin
                if (m_q[i].size() == 0) begin
                    m_err[1] = 1'b1;
                end else begin
                    popped = m_q[i].pop_front();
                    if (m_sv[i]) m_err[2] = 1'b1;
                    else begin
                        m_sv[i] = 1'b1; m_sd[i] = dat[i*W +: W]; m_si[i] = popped;
                    end
                end
            end
            if (sel[i]) begin
                if (m_q[i].size() < D) m_q[i].push_back(id);
                else m_err[0] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] b, f;
        for (int i = 0; i < N; i++) begin
            b[i] = (m_q[i].size() != 0);
            f[i] = (m_q[i].size() == D);
        end
        check("out_valid", 64'(bus.out_valid), 64'(m_ov));
        check("rd_data_out", 64'(bus.rd_data_out), 64'(m_od));
        check("op_id_out", 64'(bus.op_id_out), 64'(m_oi));
        check("sw_idx_out", 64'(bus.sw_idx_out), 64'(m_ox));
        check("sw_busy", 64'(bus.sw_busy), 64'(b));
        check("sw_full", 64'(bus.sw_full), 64'(f));
        check("err_flags", 64'(bus.err_flags), 64'(m_err));
    endtask

    task automatic cycle(input logic [N-1:0] sel, input logic [IDW-1:0] id,
                         input logic [N-1:0] ak, input logic [N*W-1:0] dat, input logic rdy);
        bus.sel_en = sel; bus.op_id = id; bus.ack = ak; bus.rd_data = dat; bus.out_ready = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(sel, id, ak, dat, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        cycle('0, '0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [N*W-1:0] put(input int ch, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_err", 64'(bus.err_flags), 64'd0);

        // Single issue/ack on channel 2, two-cycle latency
        cycle(5'b00100, 8'h11, 5'b00000, '0, 1'b1);
        check("t1_busy_rise", 64'(bus.sw_busy[2]), 64'd1);
        idle(1'b1);
        cycle(5'b00000, 8'h00, 5'b00100, put(2, 8'hA5), 1'b1);
        check("t1_busy_fall", 64'(bus.sw_busy[2]), 64'd0);
        check("t1_not_yet", 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_data", 64'(bus.rd_data_out), 64'hA5);
        check("t1_id", 64'(bus.op_id_out), 64'h11);
        check("t1_idx", 64'(bus.sw_idx_out), 64'd2);
        idle(1'b1);
        check("t1_drop", 64'(bus.out_valid), 64'd0);

        // FIFO order, fill to depth, overflow
        for (int v = 1; v <= 4; v++) cycle(5'b00001, IDW'(v), 5'b00000, '0, 1'b1);
        check("t2_full", 64'(bus.sw_full[0]), 64'd1);
        cycle(5'b00001, 8'h05, 5'b00000, '0, 1'b1);
        check("t2_ovf", 64'(bus.err_flags[ERR_OVF]), 64'd1);
        check("t2_still_full", 64'(bus.sw_full[0]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(5'b00000, 8'h00, 5'b00001, put(0, 8'hC0 + W'(k)), 1'b1);
            if (k >= 1) begin
                check("t2_order_id", 64'(bus.op_id_out), 64'(k));
                check("t2_order_data", 64'(bus.rd_data_out), 64'(8'hC0 + W'(k - 1)));
            end
        end
        idle(1'b1);
        check("t2_last_id", 64'(bus.op_id_out), 64'd4);

        // Round-robin over simultaneous acks
        do_reset();
        cycle(5'b10011, 8'h20, 5'b00000, '0, 1'b1);
        cycle(5'b00000, 8'h00, 5'b10011, 40'h44_00_00_11_00, 1'b1);
        idle(1'b1); check("t3_g0", 64'(bus.sw_idx_out), 64'd0);
        idle(1'b1); check("t3_g1", 64'(bus.sw_idx_out), 64'd1);
        idle(1'b1); check("t3_g4", 64'(bus.sw_idx_out), 64'd4);
        check("t3_g4_data", 64'(bus.rd_data_out), 64'h44);
        cycle(5'b00011, 8'h21, 5'b00000, '0, 1'b1);
        cycle(5'b00000, 8'h00, 5'b00011, 40'h00_00_00_66_55, 1'b1);
        idle(1'b1); check("t3_wrap_g0", 64'(bus.sw_idx_out), 64'd0);
        idle(1'b1); check("t3_wrap_g1", 64'(bus.sw_idx_out), 64'd1);

        // Back-pressure and response loss on channel 3
        do_reset();
        for (int v = 1; v <= 3; v++) cycle(5'b01000, 8'h30 + IDW'(v), 5'b00000, '0, 1'b1);
        cycle(5'b00000, 8'h00, 5'b01000, put(3, 8'hD1), 1'b0);
        idle(1'b0);
        cycle(5'b00000, 8'h00, 5'b01000, put(3, 8'hD2), 1'b0);
        cycle(5'b00000, 8'h00, 5'b01000, put(3, 8'hD3), 1'b0);
        check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
        check("t4_hold_id", 64'(bus.op_id_out), 64'h31);
        check("t4_lost", 64'(bus.err_flags[ERR_LOST]), 64'd1);
        check("t4_drained", 64'(bus.sw_busy[3]), 64'd0);
        idle(1'b0);
        check("t4_stable", 64'(bus.rd_data_out), 64'hD1);
        idle(1'b1);
        check("t4_next_id", 64'(bus.op_id_out), 64'h32);

        // Spurious ack, then reset with ids outstanding
        cycle(5'b00000, 8'h00, 5'b00010, put(1, 8'hEE), 1'b1);
        check("t5_spur", 64'(bus.err_flags[ERR_SPUR]), 64'd1);
        idle(1'b1);
        idle(1'b1);
        check("t5_no_valid", 64'(bus.out_valid), 64'd0);
        cycle(5'b00001, 8'h51, 5'b00000, '0, 1'b1);
        cycle(5'b00001, 8'h52, 5'b00000, '0, 1'b1);
        do_reset();
        check("t5_rst_busy", 64'(bus.sw_busy), 64'd0);
        check("t5_rst_err", 64'(bus.err_flags), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            cycle(N'($urandom & $urandom & $urandom), IDW'($urandom),
                  N'($urandom & $urandom), 40'({$urandom, $urandom}),
                  ($urandom_range(3, 0) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
